// File: rtl/mixer_pkg.sv
// Shared definitions for the MMIO stereo mixer: FSM states, register map, gain helpers.
package mixer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_SAT  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  localparam logic [4:0] REG_CTRL   = 5'd0;
  localparam logic [4:0] REG_STATUS = 5'd1;
  localparam logic [4:0] REG_GAIN0  = 5'd2;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  // Unity gain is the MSB of the gain word, i.e. 1.0 in unsigned Q1.(GAIN_W-1).
  function automatic logic [15:0] unity_gain(input int gain_w);
    return 16'(1) << (gain_w - 1);
  endfunction

endpackage

// File: rtl/mixer_sat.sv
// Arithmetic right shift of a wide accumulator followed by saturation to a PCM sample.
module mixer_sat #(
  parameter int ACC_W = 27,
  parameter int PCM_W = 16,
  parameter int SHIFT = 7
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [PCM_W-1:0] sample,
  output logic                    clip
);

  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-PCM_W+1){1'b0}}, {(PCM_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-PCM_W+1){1'b1}}, {(PCM_W-1){1'b0}}};

  logic signed [ACC_W-1:0] shifted;

  assign shifted = acc >>> SHIFT;

  always_comb begin
    clip   = 1'b0;
    sample = shifted[PCM_W-1:0];
    if (shifted > MAX_V) begin
      sample = MAX_V[PCM_W-1:0];
      clip   = 1'b1;
    end else if (shifted < MIN_V) begin
      sample = MIN_V[PCM_W-1:0];
      clip   = 1'b1;
    end
  end

endmodule

// File: rtl/mmio_mixer.sv
// N-channel PCM to stereo mixer with per-channel L/R gains, MMIO register file and clip status.
//   state | meaning
//   IDLE  | ready for a frame; capture samples and snapshot gains on i_data_valid
//   MAC   | one channel per cycle multiplied into both accumulators
//   SAT   | shift/saturate accumulators, register outputs, update clip status
//   OUT   | hold o_data_valid and outputs until i_data_ready
module mmio_mixer
  import mixer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int PCM_W  = 16,
  parameter int GAIN_W = 8
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_cs,
  input  logic                    i_write,
  input  logic                    i_read,
  input  logic [4:0]              i_addr,
  input  logic [31:0]             i_write_data,
  output logic [31:0]             o_read_data,
  input  logic [NUM_CH*PCM_W-1:0] i_pcm_in,
  input  logic                    i_data_valid,
  output logic                    o_data_ready,
  output logic [PCM_W-1:0]        o_audio_l,
  output logic [PCM_W-1:0]        o_audio_r,
  output logic                    o_data_valid,
  input  logic                    i_data_ready
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int ACC_W = PCM_W + GAIN_W + $clog2(NUM_CH) + 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [4:0]        NUM_CH_A = 5'(NUM_CH);
  localparam logic [GAIN_W-1:0] UNITY    = GAIN_W'(unity_gain(GAIN_W));

  state_t state, state_nxt;
  logic capture, mac_en, sat_en;

  logic              enable, en_frame;
  logic [GAIN_W-1:0] gain_l [NUM_CH];
  logic [GAIN_W-1:0] gain_r [NUM_CH];
  logic [GAIN_W-1:0] snap_l [NUM_CH];
  logic [GAIN_W-1:0] snap_r [NUM_CH];
  logic signed [PCM_W-1:0] pcm_q [NUM_CH];
  logic [IDX_W-1:0]  idx;

  logic signed [ACC_W-1:0] acc_l, acc_r, pcm_x, gl_x, gr_x;
  logic signed [PCM_W-1:0] sat_l, sat_r;
  logic clip_l, clip_r, frame_clip;
  logic sticky_l, sticky_r;
  logic [15:0] clip_cnt;

  logic       wr_en, clr_status, gsel;
  logic [4:0] gidx;
  logic       unused_ok;

  assign unused_ok  = ^{i_read, i_write_data};
  assign wr_en      = i_cs & i_write;
  assign gidx       = i_addr - REG_GAIN0;
  assign gsel       = (i_addr >= REG_GAIN0) && (gidx < NUM_CH_A);
  assign clr_status = wr_en && (i_addr == REG_CTRL) && i_write_data[CTRL_CLR_BIT];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (i_data_valid) state_nxt = ST_MAC;
      ST_MAC:  if (idx == LAST_IDX) state_nxt = ST_SAT;
      ST_SAT:  state_nxt = ST_OUT;
      ST_OUT:  if (i_data_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_data_ready = 1'b0;
    o_data_valid = 1'b0;
    capture      = 1'b0;
    mac_en       = 1'b0;
    sat_en       = 1'b0;
    case (state)
      ST_IDLE: begin
        o_data_ready = 1'b1;
        capture      = i_data_valid;
      end
      ST_MAC:  mac_en       = 1'b1;
      ST_SAT:  sat_en       = 1'b1;
      ST_OUT:  o_data_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      enable <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        gain_l[k] <= UNITY;
        gain_r[k] <= UNITY;
      end
    end else if (wr_en) begin
      if (i_addr == REG_CTRL) begin
        enable <= i_write_data[CTRL_EN_BIT];
      end else if (gsel) begin
        gain_l[gidx[IDX_W-1:0]] <= i_write_data[GAIN_W-1:0];
        gain_r[gidx[IDX_W-1:0]] <= i_write_data[16 +: GAIN_W];
      end
    end
  end

  // Gains are zero-extended so the signed multiply treats them as unsigned.
  assign pcm_x = ACC_W'(pcm_q[idx]);
  assign gl_x  = ACC_W'(snap_l[idx]);
  assign gr_x  = ACC_W'(snap_r[idx]);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      idx       <= '0;
      acc_l     <= '0;
      acc_r     <= '0;
      en_frame  <= 1'b0;
      o_audio_l <= '0;
      o_audio_r <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        pcm_q[k]  <= '0;
        snap_l[k] <= '0;
        snap_r[k] <= '0;
      end
    end else begin
      if (capture) begin
        for (int k = 0; k < NUM_CH; k++) begin
          pcm_q[k]  <= i_pcm_in[k*PCM_W +: PCM_W];
          snap_l[k] <= gain_l[k];
          snap_r[k] <= gain_r[k];
        end
        idx      <= '0;
        acc_l    <= '0;
        acc_r    <= '0;
        en_frame <= enable;
      end
      if (mac_en) begin
        acc_l <= acc_l + pcm_x * gl_x;
        acc_r <= acc_r + pcm_x * gr_x;
        idx   <= idx + 1'b1;
      end
      if (sat_en) begin
        o_audio_l <= en_frame ? sat_l : '0;
        o_audio_r <= en_frame ? sat_r : '0;
      end
    end
  end

  mixer_sat #(.ACC_W(ACC_W), .PCM_W(PCM_W), .SHIFT(GAIN_W-1)) u_sat_l (
    .acc(acc_l), .sample(sat_l), .clip(clip_l)
  );

  mixer_sat #(.ACC_W(ACC_W), .PCM_W(PCM_W), .SHIFT(GAIN_W-1)) u_sat_r (
    .acc(acc_r), .sample(sat_r), .clip(clip_r)
  );

  assign frame_clip = sat_en & en_frame & (clip_l | clip_r);

  // A clip landing on the same edge as a clear is kept.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sticky_l <= 1'b0;
      sticky_r <= 1'b0;
      clip_cnt <= '0;
    end else begin
      sticky_l <= (sticky_l & ~clr_status) | (sat_en & en_frame & clip_l);
      sticky_r <= (sticky_r & ~clr_status) | (sat_en & en_frame & clip_r);
      if (clr_status)
        clip_cnt <= frame_clip ? 16'd1 : 16'd0;
      else if (frame_clip && clip_cnt != 16'hFFFF)
        clip_cnt <= clip_cnt + 16'd1;
    end
  end

  always_comb begin
    o_read_data = '0;
    if (i_addr == REG_CTRL) begin
      o_read_data[CTRL_EN_BIT] = enable;
    end else if (i_addr == REG_STATUS) begin
      o_read_data = {clip_cnt, 14'b0, sticky_r, sticky_l};
    end else if (gsel) begin
      o_read_data[GAIN_W-1:0]  = gain_l[gidx[IDX_W-1:0]];
      o_read_data[16 +: GAIN_W] = gain_r[gidx[IDX_W-1:0]];
    end
  end

endmodule
